// File: rtl/mult_div_seq_if.sv
// rtl/mult_div_seq_if.sv - request/result bundle between the control unit and mult_div_seq
interface mult_div_seq_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic              op;
    logic [DATA_W-1:0] data_A;
    logic [DATA_W-1:0] data_B;
    logic              busy;
    logic              done;
    logic              div_zero;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    modport master (
        output start, op, data_A, data_B,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, data_A, data_B,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/mult_div_seq.sv
// rtl/mult_div_seq.sv - iterative signed mult/div feeding HI/LO; optional MULDIV_ZERO_SKIP_EN short-cuts zero operands
module mult_div_seq #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic             clk,
    input  logic             reset,
    mult_div_seq_if.slave    bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    localparam logic [DATA_W-1:0]   ONE  = DATA_W'(1);
    localparam logic [2*DATA_W-1:0] ONE2 = (2*DATA_W)'(1);
    localparam logic [CNT_W-1:0]    LAST = CNT_W'(DATA_W - 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                op_q, op_d;
    logic                neg_res_q, neg_res_d;
    logic                neg_rem_q, neg_rem_d;
    logic [DATA_W-1:0]   mag_q, mag_d;
    logic [DATA_W:0]     acc_hi_q, acc_hi_d;
    logic [DATA_W-1:0]   acc_lo_q, acc_lo_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic                dz_q, dz_d;

    logic                sign_a, sign_b;
    logic [DATA_W-1:0]   mag_a, mag_b;
    logic [DATA_W:0]     add_term, sum;
    logic [DATA_W:0]     shifted, diff;
    logic                ge;
    logic [2*DATA_W-1:0] prod, prod_fix;
    logic [DATA_W-1:0]   quo_fix, rem_fix;
    logic                skip;

    always_comb begin
        sign_a   = bus.data_A[DATA_W-1];
        sign_b   = bus.data_B[DATA_W-1];
        // 0x80000000 negates to itself, which read unsigned is exactly its magnitude
        mag_a    = sign_a ? (~bus.data_A + ONE) : bus.data_A;
        mag_b    = sign_b ? (~bus.data_B + ONE) : bus.data_B;

        add_term = acc_lo_q[0] ? {1'b0, mag_q} : '0;
        sum      = acc_hi_q + add_term;

        shifted  = {acc_hi_q[DATA_W-1:0], acc_lo_q[DATA_W-1]};
        ge       = shifted >= {1'b0, mag_q};
        diff     = shifted - {1'b0, mag_q};

        prod     = {acc_hi_q[DATA_W-1:0], acc_lo_q};
        prod_fix = neg_res_q ? (~prod + ONE2) : prod;
        quo_fix  = neg_res_q ? (~acc_lo_q + ONE) : acc_lo_q;
        rem_fix  = neg_rem_q ? (~acc_hi_q[DATA_W-1:0] + ONE) : acc_hi_q[DATA_W-1:0];

`ifdef MULDIV_ZERO_SKIP_EN
        skip = bus.op ? ((bus.data_A == '0) && (bus.data_B != '0))
                      : ((bus.data_A == '0) || (bus.data_B == '0));
`else
        skip = 1'b0;
`endif
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        mag_d     = mag_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dz_d      = dz_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d      = bus.op;
                    neg_res_d = sign_a ^ sign_b;
                    neg_rem_d = sign_a;
                    cnt_d     = '0;
                    acc_hi_d  = '0;
                    // mult shifts the multiplier through acc_lo; div shifts the dividend
                    mag_d     = bus.op ? mag_b : mag_a;
                    acc_lo_d  = bus.op ? mag_a : mag_b;
                    if (bus.op && (bus.data_B == '0)) begin
                        dz_d    = 1'b1;
                        state_d = S_DONE;
                    end else if (skip) begin
                        hi_d    = '0;
                        lo_d    = '0;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (op_q) begin
                    acc_hi_d = ge ? diff : shifted;
                    acc_lo_d = {acc_lo_q[DATA_W-2:0], ge};
                end else begin
                    acc_hi_d = {1'b0, sum[DATA_W:1]};
                    acc_lo_d = {sum[0], acc_lo_q[DATA_W-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (op_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*DATA_W-1:DATA_W];
                    lo_d = prod_fix[DATA_W-1:0];
                end
                state_d = S_DONE;
            end
            default: begin
                dz_d    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            mag_q     <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            mag_q     <= mag_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            dz_q      <= dz_d;
        end
    end

    assign bus.busy     = (state_q == S_RUN) || (state_q == S_FIX);
    assign bus.done     = (state_q == S_DONE);
    assign bus.div_zero = dz_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
endmodule

// File: tb/tb_mult_div_seq.sv
// tb/tb_mult_div_seq.sv - self-checking bench for mult_div_seq (vector table, directed corners, random vs arithmetic model)
module tb_mult_div_seq;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_err;
    logic [31:0] prev_hi, prev_lo;

    mult_div_seq_if #(.DATA_W(32)) bus ();

    mult_div_seq #(.DATA_W(32), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic op, input logic [31:0] a, input logic [31:0] b);
        if (op && b == 32'd0) return 0;
`ifdef MULDIV_ZERO_SKIP_EN
        if (!op && (a == 32'd0 || b == 32'd0)) return 0;
        if (op && a == 32'd0) return 0;
`endif
        return 33;
    endfunction

    task automatic model(input logic op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] h, output logic [31:0] l, output logic dz);
        longint sa, sb, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = 1'b0;
        if (!op) begin
            r = sa * sb;
            h = r[63:32];
            l = r[31:0];
        end else if (b == 32'd0) begin
            dz = 1'b1;
            h  = prev_hi;
            l  = prev_lo;
        end else begin
            r = sa % sb;
            h = r[31:0];
            r = sa / sb;
            l = r[31:0];
        end
    endtask

    // Waits for done, counting negedges after the accepting edge; busy must be high on every earlier sample.
    task automatic wait_done(output int n, output bit got, output bit busy_bad);
        n = 0;
        got = 1'b0;
        busy_bad = 1'b0;
        while (n < 80) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.done) begin
                got = 1'b1;
                break;
            end
            if (!bus.busy) busy_bad = 1'b1;
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input logic edz);
        int n;
        bit got, busy_bad;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.op     = op;
        bus.data_A = a;
        bus.data_B = b;
        @(posedge clk);
        wait_done(n, got, busy_bad);
        check({tag, " done seen"}, 64'(got), 64'd1);
        if (got) begin
            check({tag, " latency"}, 64'(n), 64'(exp_lat(op, a, b)));
            check({tag, " busy before done"}, 64'(busy_bad), 64'd0);
            check({tag, " busy with done"}, 64'(bus.busy), 64'd0);
            check({tag, " hi"}, 64'(bus.hi), 64'(eh));
            check({tag, " lo"}, 64'(bus.lo), 64'(el));
            check({tag, " div_zero"}, 64'(bus.div_zero), 64'(edz));
            @(negedge clk);
            check({tag, " done one cycle"}, 64'(bus.done), 64'd0);
            check({tag, " div_zero clears"}, 64'(bus.div_zero), 64'd0);
            check({tag, " hi holds"}, 64'(bus.hi), 64'(eh));
            check({tag, " lo holds"}, 64'(bus.lo), 64'(el));
        end
        prev_hi = eh;
        prev_lo = el;
    endtask

    logic [31:0] sp [6];

    initial begin
        int n;
        bit got, busy_bad, seen;
        logic [31:0] a, b, eh, el;
        logic op, edz;

        n_checks = 0;
        n_err    = 0;
        prev_hi  = '0;
        prev_lo  = '0;
        bus.start  = 1'b0;
        bus.op     = 1'b0;
        bus.data_A = '0;
        bus.data_B = '0;
        rst_n = 1'b0;
        sp = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h2};

        tbl.push_back('{1'b0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0});
        tbl.push_back('{1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0});
        tbl.push_back('{1'b1, 32'h00000064, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, 1'b0});
        tbl.push_back('{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0});
        tbl.push_back('{1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0});
        tbl.push_back('{1'b1, 32'h56781234, 32'h00010000, 32'h00001234, 32'h00005678, 1'b0});
        tbl.push_back('{1'b1, 32'h00000005, 32'h00000000, 32'h00001234, 32'h00005678, 1'b1});
        tbl.push_back('{1'b0, 32'h00000000, 32'h00000009, 32'h00000000, 32'h00000000, 1'b0});
        tbl.push_back('{1'b1, 32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000, 1'b0});
        tbl.push_back('{1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0});
        tbl.push_back('{1'b1, 32'h00000007, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFFF, 1'b0});
        tbl.push_back('{1'b0, 32'h00000005, 32'h00000007, 32'h00000000, 32'h00000023, 1'b0});

        repeat (3) @(negedge clk);
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        check("reset div_zero", 64'(bus.div_zero), 64'd0);
        check("reset hi", 64'(bus.hi), 64'd0);
        check("reset lo", 64'(bus.lo), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, tbl[i].dz);
        end

        // reset in the middle of a mult 5 x 7 aborts it silently
        @(negedge clk);
        bus.start = 1'b1; bus.op = 1'b0; bus.data_A = 32'd5; bus.data_B = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        check("midrun busy", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort busy", 64'(bus.busy), 64'd0);
        check("abort done", 64'(bus.done), 64'd0);
        check("abort hi", 64'(bus.hi), 64'd0);
        check("abort lo", 64'(bus.lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        prev_hi = '0;
        prev_lo = '0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen = 1'b1;
        end
        check("no done after abort", 64'(seen), 64'd0);
        run_op("after reset", 1'b0, 32'd5, 32'd7, 32'd0, 32'd35, 1'b0);

        // start held high: one op, then a fresh accept only once back in IDLE
        @(negedge clk);
        bus.start = 1'b1; bus.op = 1'b0; bus.data_A = 32'd2; bus.data_B = 32'd3;
        @(posedge clk);
        n = 0; got = 1'b0;
        while (n < 80) begin
            @(negedge clk);
            if (bus.done) begin got = 1'b1; break; end
            n++;
        end
        check("held done seen", 64'(got), 64'd1);
        check("held latency", 64'(n), 64'd33);
        check("held lo", 64'(bus.lo), 64'd6);
        @(negedge clk);
        check("held idle done", 64'(bus.done), 64'd0);
        check("held idle busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        check("held reaccept busy", 64'(bus.busy), 64'd1);
        bus.start = 1'b0;
        wait_done(n, got, busy_bad);
        check("held second done", 64'(got), 64'd1);
        check("held second lo", 64'(bus.lo), 64'd6);
        check("held second hi", 64'(bus.hi), 64'd0);
        prev_hi = 32'd0;
        prev_lo = 32'd6;
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            op = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0: begin a = $urandom; b = $urandom; end
                1: begin a = 32'($signed(16'($urandom))); b = 32'($signed(8'($urandom))); end
                default: begin a = sp[$urandom_range(0, 5)]; b = sp[$urandom_range(0, 5)]; end
            endcase
            model(op, a, b, eh, el, edz);
            run_op($sformatf("rnd%0d", i), op, a, b, eh, el, edz);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 2000000");
        $fatal(1);
    end
endmodule
